fft_frame_loader: RTL and testbench

- Streaming-to-parallel frame buffer that feeds the 8-point FFT first stage.
- Accepts one complex-packed sample per cycle over a valid/ready handshake and assembles frames of 8 samples.
- Presents each complete frame in natural order on a0..a7, with a valid/ready handshake on the frame side.
- Ping-pong double buffering: one bank fills while the other is held for the FFT stage.

---
 rtl/fft_frame_loader.sv | 117 +++++++++++
 tb/tb_fft_frame_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Streaming-to-parallel ping-pong frame buffer: assembles 8-sample frames from a
// valid/ready sample stream and presents each complete frame on a0..a7.
module fft_frame_loader #(
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**N-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    output logic [2**N-1:0] a0,
    output logic [2**N-1:0] a1,
    output logic [2**N-1:0] a2,
    output logic [2**N-1:0] a3,
    output logic [2**N-1:0] a4,
    output logic [2**N-1:0] a5,
    output logic [2**N-1:0] a6,
    output logic [2**N-1:0] a7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sof_err
);

    localparam int unsigned W     = 2**N;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IW    = 3;

    logic [W-1:0]  bank_q [2][DEPTH];
    logic [W-1:0]  bank_d [2][DEPTH];
    logic [W-1:0]  a_q    [DEPTH];
    logic [W-1:0]  a_d    [DEPTH];
    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [IW-1:0] widx_q, widx_d;
    logic          sof_err_q, sof_err_d;
    logic          accept, take;

    assign accept = in_valid && !full_q[wbank_q];
    assign take   = full_q[rbank_q] && out_ready;

    // Next-state: frame take and sample accept always hit different banks.
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wbank_d   = wbank_q;
        rbank_d   = rbank_q;
        widx_d    = widx_q;
        sof_err_d = 1'b0;
        a_d       = a_q;

        if (take) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end

        if (accept) begin
            if (in_sof && (widx_q != IW'(0))) begin
                // Restart the frame: drop the partial, this sample becomes slot 0.
                bank_d[wbank_q][0] = in_data;
                widx_d             = IW'(1);
                sof_err_d          = 1'b1;
            end else begin
                bank_d[wbank_q][widx_q] = in_data;
                widx_d                  = widx_q + IW'(1);
                if (widx_q == IW'(DEPTH - 1)) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                end
            end
        end

        if (full_d[rbank_d]) begin
            a_d = bank_d[rbank_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
            end
            full_q    <= '0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            widx_q    <= '0;
            sof_err_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            a_q       <= a_d;
            full_q    <= full_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            widx_q    <= widx_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign in_ready  = !full_q[wbank_q];
    assign out_valid = full_q[rbank_q];
    assign sof_err   = sof_err_q;
    assign a0 = a_q[0];
    assign a1 = a_q[1];
    assign a2 = a_q[2];
    assign a3 = a_q[3];
    assign a4 = a_q[4];
    assign a5 = a_q[5];
    assign a6 = a_q[6];
    assign a7 = a_q[7];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader.
module tb_fft_frame_loader;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [15:0] a [8];
    logic        out_valid;
    logic        out_ready;
    logic        sof_err;

    int n_pass  = 0;
    int n_total = 0;

    fft_frame_loader #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_ready (in_ready),
        .a0       (a[0]),
        .a1       (a[1]),
        .a2       (a[2]),
        .a3       (a[3]),
        .a4       (a[4]),
        .a5       (a[5]),
        .a6       (a[6]),
        .a7       (a[7]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sof_err  (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sample presented for one clock edge.
    task automatic send(input logic [15:0] d, input logic sof);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (sof_err !== 1'b0) $display("FAIL reset_sof_err got=%b exp=0", sof_err); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (a[i] !== 16'h0) $display("FAIL reset_a%0d got=%h exp=0000", i, a[i]); else n_pass++;
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(16'(i + 1), i == 0);
            if (i < 7) begin
                n_total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid i=%0d got=%b exp=0", i, out_valid); else n_pass++;
            end
        end
        n_total++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid got=%b exp=1", out_valid); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (a[i] !== 16'(i + 1)) $display("FAIL basic_a%0d got=%h exp=%h", i, a[i], 16'(i + 1)); else n_pass++;
        end
        n_total++; if (sof_err !== 1'b0) $display("FAIL basic_sof_err got=%b exp=0", sof_err); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_taken got=%b exp=0", out_valid); else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) begin
            n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready i=%0d got=%b exp=1", i, in_ready); else n_pass++;
            send(16'h0100 + 16'(i), 1'b0);
        end
        // Sample 0x0110 offered while both banks are full.
        in_valid = 1'b1; in_data = 16'h0110; in_sof = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_stall_ready c=%0d got=%b exp=0", c, in_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_stall_valid c=%0d got=%b exp=1", c, out_valid); else n_pass++;
            n_total++; if (a[0] !== 16'h0100) $display("FAIL bp_stall_a0 c=%0d got=%h exp=0100", c, a[0]); else n_pass++;
            step();
        end
        n_total++; if (a[7] !== 16'h0107) $display("FAIL bp_a7 got=%h exp=0107", a[7]); else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_total++; if (a[0] !== 16'h0108) $display("FAIL bp_release_a0 got=%h exp=0108", a[0]); else n_pass++;
        n_total++; if (a[7] !== 16'h010F) $display("FAIL bp_release_a7 got=%h exp=010f", a[7]); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) send(16'h0110 + 16'(i), 1'b0);
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_refill_ready got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (a[0] !== 16'h0108) $display("FAIL bp_refill_a0 got=%h exp=0108", a[0]); else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++; if (a[0] !== 16'h0110) $display("FAIL bp_freed_a0 got=%h exp=0110", a[0]); else n_pass++;
        n_total++; if (a[7] !== 16'h0117) $display("FAIL bp_freed_a7 got=%h exp=0117", a[7]); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_freed_valid got=%b exp=1", out_valid); else n_pass++;
        step();
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_sof_restart();
        send(16'h00C1, 1'b1);
        send(16'h00C2, 1'b0);
        send(16'h00C3, 1'b0);
        send(16'h00AA, 1'b1);
        n_total++; if (sof_err !== 1'b1) $display("FAIL sof_pulse got=%b exp=1", sof_err); else n_pass++;
        for (int i = 1; i < 8; i++) begin
            send(16'h00B0 + 16'(i), 1'b0);
            n_total++; if (sof_err !== 1'b0) $display("FAIL sof_single i=%0d got=%b exp=0", i, sof_err); else n_pass++;
        end
        n_total++; if (out_valid !== 1'b1) $display("FAIL sof_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (a[0] !== 16'h00AA) $display("FAIL sof_a0 got=%h exp=00aa", a[0]); else n_pass++;
        for (int i = 1; i < 8; i++) begin
            n_total++; if (a[i] !== 16'h00B0 + 16'(i)) $display("FAIL sof_a%0d got=%h exp=%h", i, a[i], 16'h00B0 + 16'(i)); else n_pass++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        // Restart landing on the last slot must not complete the bank.
        for (int i = 0; i < 7; i++) send(16'h00E0 + 16'(i), i == 0);
        send(16'h00DD, 1'b1);
        n_total++; if (sof_err !== 1'b1) $display("FAIL sof_last_pulse got=%b exp=1", sof_err); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL sof_last_not_full got=%b exp=0", out_valid); else n_pass++;
        for (int i = 1; i < 8; i++) send(16'h00D0 + 16'(i), 1'b0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL sof_last_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (a[0] !== 16'h00DD) $display("FAIL sof_last_a0 got=%h exp=00dd", a[0]); else n_pass++;
        n_total++; if (a[7] !== 16'h00D7) $display("FAIL sof_last_a7 got=%h exp=00d7", a[7]); else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready k=%0d got=%b exp=1", k, in_ready); else n_pass++;
            send(16'h0200 + 16'(k), (k % 8) == 0);
            n_total++;
            if (out_valid !== ((k % 8) == 7)) $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, out_valid, (k % 8) == 7);
            else n_pass++;
            if ((k % 8) == 7) begin
                n_total++; if (a[0] !== 16'h0200 + 16'(k - 7)) $display("FAIL b2b_a0 k=%0d got=%h exp=%h", k, a[0], 16'h0200 + 16'(k - 7)); else n_pass++;
                n_total++; if (a[7] !== 16'h0200 + 16'(k)) $display("FAIL b2b_a7 k=%0d got=%h exp=%h", k, a[7], 16'h0200 + 16'(k)); else n_pass++;
            end
        end
        step();
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 13; i++) send(16'h0300 + 16'(i), (i % 8) == 0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL ar_pre_valid got=%b exp=1", out_valid); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL ar_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL ar_ready got=%b exp=1", in_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (a[i] !== 16'h0) $display("FAIL ar_a%0d got=%h exp=0000", i, a[i]); else n_pass++;
        end
        rst = 1'b1;
        step();
        for (int i = 0; i < 7; i++) send(16'h0400 + 16'(i), i == 0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL ar_partial got=%b exp=0", out_valid); else n_pass++;
        send(16'h0407, 1'b0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL ar_fresh_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (a[0] !== 16'h0400) $display("FAIL ar_fresh_a0 got=%h exp=0400", a[0]); else n_pass++;
        n_total++; if (a[7] !== 16'h0407) $display("FAIL ar_fresh_a7 got=%h exp=0407", a[7]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_sof_restart();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
